// File: rtl/i2s_mic_stereo_receiver_if.sv
// Sample stream from the I2S receiver to its consumer.
// Latency: n/a (signal bundle only).
// Backpressure: sample_valid/sample_ready; data holds while valid && !ready.
//
// Ports (modports):
//   master - receiver side: drives sample, sample_ch, sample_valid; reads sample_ready
//   slave  - consumer side: reads sample, sample_ch, sample_valid; drives sample_ready
interface i2s_mic_stereo_receiver_if #(
  parameter int w_sample = 24
);
  logic [w_sample-1:0] sample;        // captured word, two's-complement
  logic                sample_ch;     // 0 = left, 1 = right
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output sample,
    output sample_ch,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_ch,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_mic_stereo_receiver.sv
// I2S master receiver: generates SCK/WS, deserialises 24-bit words from one SD line (left slot 0, right slot 1).
// Latency: sample_valid rises on the clk edge after the edge that captures bit 24 (197 clk after slot start at defaults).
// Backpressure: a word completing while a sample is still unaccepted is dropped and sets sticky overflow.
//
// Ports:
//   clk, rst      - system clock; async active-low reset
//   sck, ws, sd   - I2S pins (sck/ws registered outputs, sd serial input)
//   smp           - sample stream (master modport of i2s_mic_stereo_receiver_if)
//   overflow      - sticky drop flag, cleared by overflow_clr (a same-cycle drop wins)
//   peak/peak_clr - peak magnitude hold; present only with I2S_MIC_PEAK_HOLD_EN defined,
//                   otherwise peak is tied to 0 and peak_clr is ignored
module i2s_mic_stereo_receiver #(
  parameter int clk_mhz    = 25,
  parameter int sck_div    = 4,
  parameter int w_sample   = 24,
  parameter int n_channels = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      sck,
  output logic                      ws,
  input  logic                      sd,
  i2s_mic_stereo_receiver_if.master smp,
  output logic                      overflow,
  input  logic                      overflow_clr,
  output logic [w_sample-1:0]       peak,
  input  logic                      peak_clr
);

  // Elaboration-time parameter sanity checks.
  if (clk_mhz < 1) begin : g_bad_clk
    $error("clk_mhz must be positive");
  end
  if (sck_div < 2) begin : g_bad_div
    $error("sck_div must be >= 2");
  end
  if (w_sample < 1 || w_sample > 24) begin : g_bad_width
    $error("w_sample must be in 1..24");
  end
  if (n_channels < 1 || n_channels > 2) begin : g_bad_chan
    $error("n_channels must be 1 or 2");
  end

  localparam int dw = (sck_div > 1) ? $clog2(sck_div) : 1;

  logic [dw-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [5:0]    bit_cnt_nxt;
  logic [23:0]   shreg;
  logic          cmp_vld;   // a word completed on the previous edge
  logic          cmp_ch;
  logic          tc;
  logic          rise;
  logic          fall;
  logic          cap;
  logic          done;
  logic          load;
  logic          drop;

  assign tc          = (div_cnt == dw'(sck_div - 1));
  assign rise        = tc & ~sck;
  assign fall        = tc & sck;
  assign bit_cnt_nxt = bit_cnt + 6'd1;

  // Slot bit 0 is the I2S one-bit delay; bits 25..31 are padding.
  assign cap  = rise && (bit_cnt[4:0] >= 5'd1) && (bit_cnt[4:0] <= 5'd24);
  // Right-slot words are never flagged in mono mode, so they vanish without touching overflow.
  assign done = rise && (bit_cnt[4:0] == 5'd24) && ((n_channels > 1) || !bit_cnt[5]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      cmp_vld <= 1'b0;
      cmp_ch  <= 1'b0;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + dw'(1);
      if (tc) begin
        sck <= ~sck;
      end
      // WS follows the new slot number, so it changes on the SCK fall that opens bit 0.
      if (fall) begin
        bit_cnt <= bit_cnt_nxt;
        ws      <= bit_cnt_nxt[5];
      end
      if (cap) begin
        shreg <= {shreg[22:0], sd};
      end
      cmp_vld <= done;
      if (done) begin
        cmp_ch <= bit_cnt[5];
      end
    end
  end

  // Output register: shreg stays stable for several clk after bit 24, so it is read one edge later.
  assign load = cmp_vld && (!smp.sample_valid || smp.sample_ready);
  assign drop = cmp_vld && smp.sample_valid && !smp.sample_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp.sample       <= '0;
      smp.sample_ch    <= 1'b0;
      smp.sample_valid <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      if (load) begin
        smp.sample       <= shreg[23 -: w_sample];
        smp.sample_ch    <= cmp_ch;
        smp.sample_valid <= 1'b1;
      end else if (smp.sample_ready) begin
        smp.sample_valid <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef I2S_MIC_PEAK_HOLD_EN
  localparam logic [w_sample-1:0] max_pos = w_sample'((1 << (w_sample - 1)) - 1);
  localparam logic [w_sample-1:0] min_neg = ~max_pos;

  logic [w_sample-1:0] new_s;
  logic [w_sample-1:0] mag;

  assign new_s = shreg[23 -: w_sample];

  // |x| with the most negative code saturated, since its negation does not fit.
  always_comb begin
    mag = new_s;
    if (new_s[w_sample-1]) begin
      if (new_s == min_neg) begin
        mag = max_pos;
      end else begin
        mag = -new_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak <= '0;
    end else if (load) begin
      if (peak_clr || (mag > peak)) begin
        peak <= mag;
      end
    end else if (peak_clr) begin
      peak <= '0;
    end
  end
`else
  logic unused_peak_clr;

  assign peak            = '0;
  assign unused_peak_clr = peak_clr;
`endif

endmodule
